// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths, slot layout and slot counter type for the I2S transmitter
package i2s_pkg;
    localparam int SAMPLE_W       = 16;
    localparam int FRAME_BITS     = 32;
    localparam int LEFT_LAST_SLOT = 15;
    typedef logic [4:0] slot_t;
    localparam slot_t LAST_SLOT   = 5'd31;
endpackage

// File: rtl/i2s_bck_div.sv
// i2s_bck_div: prescaler producing the I2S bit clock and a one-clk falling-edge enable
module i2s_bck_div #(
    parameter int BCK_HALF = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic bck_o,
    output logic fall_en_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       bck_q, bck_d;
    logic       tc;

    assign tc        = cnt_q == 8'(BCK_HALF - 1);
    assign fall_en_o = tc & bck_q;
    assign bck_o     = bck_q;

    // wrap the prescaler on terminal count and toggle BCK there
    always_comb begin
        cnt_d = tc ? '0 : cnt_q + 8'd1;
        bck_d = bck_q ^ tc;
    end

    // prescaler and BCK registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            bck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bck_q <= bck_d;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serialiser, 16-bit stereo, 32 BCK per frame; I2S_UNSIGNED_IN_EN flips sample MSBs at capture
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int BCK_HALF = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    output logic                sample_stb_o,
    output logic                I2S_BCK,
    output logic                I2S_LRCK,
    output logic                I2S_DATA
);
`ifdef I2S_UNSIGNED_IN_EN
    localparam logic [SAMPLE_W-1:0] FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};
`else
    localparam logic [SAMPLE_W-1:0] FLIP = '0;
`endif

    logic                  fall_en;
    slot_t                 k_q, k_d;
    logic                  lrck_q, lrck_d;
    logic                  data_q, data_d;
    logic                  stb_q, stb_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d, capture;

    i2s_bck_div #(.BCK_HALF(BCK_HALF)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .bck_o     (I2S_BCK),
        .fall_en_o (fall_en)
    );

    assign capture = {left_i ^ FLIP, right_i ^ FLIP};

    // advance slot on each BCK fall; slot k sends frame bit (32-k) mod 32, so k=0 reuses the old frame's LSB before reload
    always_comb begin
        k_d     = fall_en ? k_q + 5'd1 : k_q;
        lrck_d  = fall_en ? (k_d > slot_t'(LEFT_LAST_SLOT)) : lrck_q;
        data_d  = fall_en ? frame_q[5'd0 - k_d] : data_q;
        stb_d   = fall_en && k_d == '0;
        frame_d = stb_d ? capture : frame_q;
    end

    // slot, word-select, data, frame and strobe registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_q     <= LAST_SLOT;
            lrck_q  <= 1'b1;
            data_q  <= 1'b0;
            stb_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            k_q     <= k_d;
            lrck_q  <= lrck_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            frame_q <= frame_d;
        end
    end

    assign I2S_LRCK     = lrck_q;
    assign I2S_DATA     = data_q;
    assign sample_stb_o = stb_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx at BCK_HALF=16 and BCK_HALF=2 with an I2S receiver model
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] left_i = '0, right_i = '0;
    logic        stb [2];
    logic        bck [2];
    logic        lrck [2];
    logic        data [2];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0;
    int          rel;
    logic [15:0] l1 [$], r1 [$], l2 [$], r2 [$];
    int          s1 [$], s2 [$];
    int          n [2];
    logic [15:0] sh [2];
    logic        lrp [2], bp [2], curlr [2];
    int          b2_rise = 0, b2_prev = 0;
    logic [15:0] exp_l, exp_r;

    i2s_tx #(.BCK_HALF(16)) dut (
        .clk(clk), .reset_n(reset_n), .left_i(left_i), .right_i(right_i),
        .sample_stb_o(stb[0]), .I2S_BCK(bck[0]), .I2S_LRCK(lrck[0]), .I2S_DATA(data[0])
    );

    i2s_tx #(.BCK_HALF(2)) dut_fast (
        .clk(clk), .reset_n(reset_n), .left_i(left_i), .right_i(right_i),
        .sample_stb_o(stb[1]), .I2S_BCK(bck[1]), .I2S_LRCK(lrck[1]), .I2S_DATA(data[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int i, input logic lr, input logic [15:0] w);
        if (i == 0) begin
            if (lr) r1.push_back(w); else l1.push_back(w);
        end else begin
            if (lr) r2.push_back(w); else l2.push_back(w);
        end
    endtask

    task automatic wait_stb();
        int t = 0;
        @(negedge clk);
        while (!stb[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("stb_seen", 32'(stb[0]), 32'd1);
    endtask

    task automatic clear_q();
        l1.delete(); r1.delete(); l2.delete(); r2.delete(); s1.delete(); s2.delete();
    endtask

    // receiver: sample on BCK rise; an LRCK change marks the skip bit, then 16 bits form a word
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                n[i] = 16; lrp[i] = 1'b1; bp[i] = 1'b0; curlr[i] = 1'b1;
            end else begin
                if (stb[i]) begin
                    if (i == 0) s1.push_back(cyc); else s2.push_back(cyc);
                end
                if (bck[i] && !bp[i]) begin
                    if (i == 1) begin b2_prev = b2_rise; b2_rise = cyc; end
                    if (n[i] < 16) begin
                        sh[i] = {sh[i][14:0], data[i]};
                        n[i]++;
                        if (n[i] == 16) push_word(i, curlr[i], sh[i]);
                    end
                    if (lrck[i] != lrp[i]) begin n[i] = 0; curlr[i] = lrck[i]; end
                    lrp[i] = lrck[i];
                end
                bp[i] = bck[i];
            end
        end
    end

    initial begin
        left_i = 16'hA5C3; right_i = 16'h1234;
        repeat (10) @(negedge clk);
        check("rst_bck", 32'(bck[0]), 32'd0);
        check("rst_lrck", 32'(lrck[0]), 32'd1);
        check("rst_data", 32'(data[0]), 32'd0);
        check("rst_stb", 32'(stb[0]), 32'd0);
        check("rst_lrck_fast", 32'(lrck[1]), 32'd1);
        clear_q();
        reset_n = 1'b1;
        rel = cyc;
        wait_stb();
        check("first_stb_lat", 32'(cyc - rel), 32'd32);
        repeat (3200) @(negedge clk);
        check("left_words", 32'(l1.size() >= 2), 32'd1);
        check("left0", 32'(l1[0]), 32'hA5C3);
        check("left1", 32'(l1[1]), 32'hA5C3);
        check("right0", 32'(r1[0]), 32'h1234);
        check("right1", 32'(r1[1]), 32'h1234);
        check("stb_period", 32'(s1[1] - s1[0]), 32'd1024);
        check("fast_first_stb", 32'(s2[0] - rel), 32'd4);
        check("fast_stb_period", 32'(s2[1] - s2[0]), 32'd128);
        check("fast_bck_period", 32'(b2_rise - b2_prev), 32'd4);
        check("fast_left", 32'(l2[l2.size()-1]), 32'hA5C3);
        check("fast_right", 32'(r2[r2.size()-1]), 32'h1234);

        wait_stb();
        left_i = 16'h0001;
        clear_q();
        wait_stb();
        repeat (160) @(negedge clk);
        left_i = 16'h8000;
        wait_stb();
        repeat (600) @(negedge clk);
        check("win_count", 32'(l1.size()), 32'd3);
        check("win_prev", 32'(l1[0]), 32'hA5C3);
        check("win_cur", 32'(l1[1]), 32'h0001);
        check("win_next", 32'(l1[2]), 32'h8000);

        wait_stb();
        repeat (640) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_bck", 32'(bck[0]), 32'd0);
        check("mid_rst_lrck", 32'(lrck[0]), 32'd1);
        check("mid_rst_data", 32'(data[0]), 32'd0);
        check("mid_rst_stb", 32'(stb[0]), 32'd0);
        left_i = 16'h1357; right_i = 16'h2468;
        clear_q();
        reset_n = 1'b1;
        rel = cyc;
        wait_stb();
        check("mid_first_stb", 32'(cyc - rel), 32'd32);
        repeat (1100 - 32) @(negedge clk);
        check("mid_left_cnt", 32'(l1.size()), 32'd1);
        check("mid_right_cnt", 32'(r1.size()), 32'd1);
        check("mid_left", 32'(l1[0]), 32'h1357);
        check("mid_right", 32'(r1[0]), 32'h2468);

        left_i = 16'h8000; right_i = 16'hFFFF;
`ifdef I2S_UNSIGNED_IN_EN
        exp_l = 16'h0000; exp_r = 16'h7FFF;
`else
        exp_l = 16'h8000; exp_r = 16'hFFFF;
`endif
        wait_stb();
        wait_stb();
        repeat (600) @(negedge clk);
        check("fmt_left", 32'(l1[l1.size()-1]), 32'(exp_l));
        check("fmt_right", 32'(r1[r1.size()-1]), 32'(exp_r));
        check("fmt_left_fast", 32'(l2[l2.size()-1]), 32'(exp_l));
        check("fmt_right_fast", 32'(r2[r2.size()-1]), 32'(exp_r));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
